input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
Board-input front end placed between the raw SW/KEY pins (or the emulator's input vector) and the design under test. It synchronises every input bit, debounces it, and converts the active-low KEY buttons into active-high level, press, release and auto-repeat pulses. SW levels are delivered clean, together with a change strobe. The DUT consumes these registered, glitch-free signals instead of raw pins.

Parameters:
N_KEYS, 4, number of push-buttons.
N_SW, 10, number of slide switches.
DEBOUNCE_CYCLES, 16, consecutive differing samples required to accept a new level (>=1).
REPEAT_DELAY, 64, cycles from accepted press to first repeat pulse; 0 disables auto-repeat.
REPEAT_PERIOD, 16, cycles between subsequent repeat pulses (>=1).

Ports:
CLK  in  1  system clock; all state on rising edge.
RST_N  in  1  asynchronous active-low reset.
KEY_IN  in  N_KEYS  raw buttons, active-low (0 = pressed).
SW_IN  in  N_SW  raw switch levels.
KEY_LVL  out  N_KEYS  debounced button state, active-high (1 = pressed).
KEY_PRESS  out  N_KEYS  one-cycle pulse on accepted press.
KEY_RELEASE  out  N_KEYS  one-cycle pulse on accepted release.
KEY_REPEAT  out  N_KEYS  one-cycle auto-repeat pulses while held.
SW_OUT  out  N_SW  debounced switch levels.
SW_CHANGED  out  1  one-cycle pulse when any SW_OUT bit changes.

Behaviour:
- Reset (RST_N=0, asynchronous): KEY sync flops = 1 (released), SW sync flops = 0, all debounce counters = 0, repeat FSMs = IDLE. All outputs = 0. No pulses are produced while in reset or on the first edge after reset release.
- Synchroniser: 2-flop chain per bit; s2 is the synchronised sample.
- Debounce, identical per bit: stable register st. If s2 == st, the counter clears. If s2 != st, the counter increments. On the edge where the counter == DEBOUNCE_CYCLES-1 and s2 != st, st <= s2 and the counter clears.
- Latency: a raw change held steadily is accepted on the (2+DEBOUNCE_CYCLES)-th rising edge after it is first sampled.
- Glitches shorter than DEBOUNCE_CYCLES samples never change st. Any sample equal to st restarts the count.
- KEY_LVL = ~st. SW_OUT = st. Both are registered.
- KEY_PRESS[i] and KEY_RELEASE[i] are registered and high for exactly the one cycle following the edge where KEY_LVL[i] rises or falls, respectively, i.e. they are coincident with the new KEY_LVL value.
- SW_CHANGED is high for the one cycle in which any SW_OUT bit holds a new value. Multiple bits flipping on the same edge produce a single pulse.
- Repeat FSM, per key, with a cycle counter:
  - IDLE -> DELAY on accepted press; the counter is cleared.
  - DELAY: counter increments each cycle while KEY_LVL is high. When it reaches REPEAT_DELAY, KEY_REPEAT pulses and the FSM moves to REPEAT with the counter cleared.
  - REPEAT: a pulse every REPEAT_PERIOD cycles.
  - Accepted release in any state -> IDLE immediately; no repeat pulse in the release cycle.
  - If REPEAT_DELAY = 0, the FSM stays in IDLE and KEY_REPEAT stays 0.
  - KEY_PRESS and KEY_REPEAT are never high in the same cycle.
- Keys and switches are fully independent: simultaneous events on different bits are handled in parallel.
- Counter widths are $clog2 of (max parameter + 1). Counters saturate and never wrap.
- Reset mid-operation: the state returns to reset values. If a key is still held after RST_N rises, it is re-detected as a fresh press (KEY_PRESS after 2+DEBOUNCE_CYCLES edges).

Test Plan (defaults, edge 0 = first edge sampling the new raw value):
- KEY_IN[0] driven 0 and held -> KEY_LVL[0]=1 with a one-cycle KEY_PRESS[0] after edge 17. KEY_REPEAT[0] pulses after edges 81, 97, 113. Other keys stay 0.
- KEY_IN[1] low for 15 cycles then high, repeated 5 times -> KEY_LVL, KEY_PRESS, KEY_RELEASE and KEY_REPEAT for key 1 all remain 0.
- Key 0 held to edge 90, then KEY_IN[0]=1 -> KEY_RELEASE[0] pulse after edge 107. No KEY_REPEAT after the release is accepted; FSM back in IDLE.
- SW_IN = 10'h201 applied from 0 on a single edge -> SW_OUT = 10'h201 after edge 17. SW_CHANGED is high for exactly one cycle.
- KEY_IN[2] and KEY_IN[3] pressed 3 cycles apart -> two independent KEY_PRESS pulses 3 cycles apart.
- RST_N pulsed low at edge 40 while KEY_IN[0] is held -> all outputs 0 immediately. KEY_PRESS[0] re-fires 18 edges after RST_N rises.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Board-pin bundle between the raw SW/KEY inputs and the conditioned, registered outputs.
// master drives the raw pins; slave is the conditioner.
interface input_conditioner_if #(
    parameter int N_KEYS = 4,
    parameter int N_SW   = 10
);
    logic [N_KEYS-1:0] KEY_IN;
    logic [N_SW-1:0]   SW_IN;
    logic [N_KEYS-1:0] KEY_LVL;
    logic [N_KEYS-1:0] KEY_PRESS;
    logic [N_KEYS-1:0] KEY_RELEASE;
    logic [N_KEYS-1:0] KEY_REPEAT;
    logic [N_SW-1:0]   SW_OUT;
    logic              SW_CHANGED;

    modport master (
        output KEY_IN, SW_IN,
        input  KEY_LVL, KEY_PRESS, KEY_RELEASE, KEY_REPEAT, SW_OUT, SW_CHANGED
    );

    modport slave (
        input  KEY_IN, SW_IN,
        output KEY_LVL, KEY_PRESS, KEY_RELEASE, KEY_REPEAT, SW_OUT, SW_CHANGED
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronise + debounce KEY/SW pins; keys yield level, press, release and auto-repeat pulses.
// Latency 2+DEBOUNCE_CYCLES edges from raw change to output; free-running, no backpressure.
module input_conditioner #(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input logic                CLK,
    input logic                RST_N,
    input_conditioner_if.slave io
);
    localparam int NB   = N_KEYS + N_SW;
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST  = RW'(REPEAT_PERIOD - 1);
    // Keys idle high (released), switches idle low; keys and switches share one debounce vector.
    localparam logic [NB-1:0] SYNC_RST = {{N_SW{1'b0}}, {N_KEYS{1'b1}}};

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_DELAY  = 2'd1,
        R_REPEAT = 2'd2
    } rep_state_e;

    logic [NB-1:0]          s1_q, s1_d, s2_q, s2_d, st_q, st_d;
    logic [NB-1:0][DW-1:0]  db_cnt_q, db_cnt_d;
    logic [NB-1:0]          acc;
    logic [N_KEYS-1:0]      press_q, press_d, release_q, release_d, repeat_q, repeat_d;
    logic                   sw_chg_q, sw_chg_d;
    logic [N_KEYS-1:0][RW-1:0] rcnt_q, rcnt_d;
    rep_state_e             state_q [N_KEYS];
    rep_state_e             state_d [N_KEYS];

    function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] v);
        return (v == {RW{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Synchroniser and per-bit debounce.
    always_comb begin
        s1_d     = {io.SW_IN, io.KEY_IN};
        s2_d     = s1_q;
        st_d     = st_q;
        db_cnt_d = '0;
        acc      = '0;
        for (int i = 0; i < NB; i++) begin
            if (s2_q[i] != st_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    acc[i]  = 1'b1;
                    st_d[i] = s2_q[i];
                end else if (db_cnt_q[i] != {DW{1'b1}}) begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i];
                end
            end
        end
        press_d   = acc[N_KEYS-1:0] & ~s2_q[N_KEYS-1:0];
        release_d = acc[N_KEYS-1:0] &  s2_q[N_KEYS-1:0];
        sw_chg_d  = |acc[NB-1:N_KEYS];
    end

    // Auto-repeat FSM; release is checked first so it always wins over a pending pulse.
    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        repeat_d = '0;
        if (REPEAT_DELAY != 0) begin
            for (int k = 0; k < N_KEYS; k++) begin
                if (release_d[k]) begin
                    state_d[k] = R_IDLE;
                    rcnt_d[k]  = '0;
                end else begin
                    case (state_q[k])
                        R_IDLE: begin
                            if (press_d[k]) begin
                                state_d[k] = R_DELAY;
                                rcnt_d[k]  = '0;
                            end
                        end
                        R_DELAY: begin
                            if (rcnt_q[k] == RD_LAST) begin
                                repeat_d[k] = 1'b1;
                                state_d[k]  = R_REPEAT;
                                rcnt_d[k]   = '0;
                            end else begin
                                rcnt_d[k] = sat_inc(rcnt_q[k]);
                            end
                        end
                        R_REPEAT: begin
                            if (rcnt_q[k] == RP_LAST) begin
                                repeat_d[k] = 1'b1;
                                rcnt_d[k]   = '0;
                            end else begin
                                rcnt_d[k] = sat_inc(rcnt_q[k]);
                            end
                        end
                        default: begin
                            state_d[k] = R_IDLE;
                            rcnt_d[k]  = '0;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q      <= SYNC_RST;
            s2_q      <= SYNC_RST;
            st_q      <= SYNC_RST;
            db_cnt_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            sw_chg_q  <= 1'b0;
            rcnt_q    <= '0;
            for (int k = 0; k < N_KEYS; k++) state_q[k] <= R_IDLE;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            st_q      <= st_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            sw_chg_q  <= sw_chg_d;
            rcnt_q    <= rcnt_d;
            state_q   <= state_d;
        end
    end

    assign io.KEY_LVL     = ~st_q[N_KEYS-1:0];
    assign io.SW_OUT      = st_q[NB-1:N_KEYS];
    assign io.KEY_PRESS   = press_q;
    assign io.KEY_RELEASE = release_q;
    assign io.KEY_REPEAT  = repeat_q;
    assign io.SW_CHANGED  = sw_chg_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed key/switch scenarios plus a window-based reference model.
module tb_input_conditioner;
    localparam int NK = 4;
    localparam int NS = 10;
    localparam int NB = NK + NS;
    localparam int DB = 16;
    localparam int RD = 64;
    localparam int RP = 16;
    localparam logic [NB-1:0] RSTV = {10'h000, 4'hF};

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    input_conditioner_if #(.N_KEYS(NK), .N_SW(NS)) io ();

    input_conditioner #(
        .N_KEYS(NK), .N_SW(NS), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .io   (io)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a level is accepted when the last DB synchronised samples all differ
    // from the current accepted level; repeats are pure arithmetic on edges since press.
    logic [NB-1:0] hist [$];
    logic [NB-1:0] mst;
    int            press_edge [NK];
    int            n_edge = 0;
    logic [NK-1:0] e_lvl, e_prs, e_rel, e_rep;
    logic [NS-1:0] e_sw;
    logic          e_chg;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DB + 2; i++) hist.push_back(RSTV);
        mst = RSTV;
        for (int k = 0; k < NK; k++) press_edge[k] = -1;
        e_lvl = '0; e_prs = '0; e_rel = '0; e_rep = '0; e_sw = '0; e_chg = 1'b0;
    endtask

    task automatic model_step();
        logic [NB-1:0] acc;
        bit all_diff;
        int d;
        n_edge++;
        hist.push_back({io.SW_IN, io.KEY_IN});
        if (hist.size() > DB + 3) void'(hist.pop_front());
        acc = '0;
        for (int i = 0; i < NB; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++)
                if (hist[hist.size() - 3 - j][i] == mst[i]) all_diff = 1'b0;
            acc[i] = all_diff;
        end
        mst   = mst ^ acc;
        e_lvl = ~mst[NK-1:0];
        e_prs = acc[NK-1:0] & ~mst[NK-1:0];
        e_rel = acc[NK-1:0] &  mst[NK-1:0];
        e_sw  = mst[NB-1:NK];
        e_chg = |acc[NB-1:NK];
        for (int k = 0; k < NK; k++) begin
            if (e_prs[k]) press_edge[k] = n_edge;
            if (e_rel[k]) press_edge[k] = -1;
            e_rep[k] = 1'b0;
            if (RD > 0 && press_edge[k] >= 0 && !e_prs[k]) begin
                d = n_edge - press_edge[k];
                if (d >= RD && ((d - RD) % RP) == 0) e_rep[k] = 1'b1;
            end
        end
    endtask

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) model_reset();
        else        model_step();
    end

    initial forever begin
        @(posedge CLK);
        #1;
        if (cmp_en)
            chk("model", 32'({io.KEY_LVL, io.KEY_PRESS, io.KEY_RELEASE, io.KEY_REPEAT, io.SW_OUT, io.SW_CHANGED}),
                         32'({e_lvl, e_prs, e_rel, e_rep, e_sw, e_chg}));
    end

    logic act1;
    task automatic tick_key1(input int n);
        repeat (n) begin
            @(negedge CLK);
            act1 = act1 | io.KEY_LVL[1] | io.KEY_PRESS[1] | io.KEY_RELEASE[1] | io.KEY_REPEAT[1];
        end
    endtask

    int reps [$];
    int prs_e, prs_n, rel_e, chg_e, chg_n, p2, p3;
    logic other;

    initial begin
        RST_N     = 1'b0;
        io.KEY_IN = '1;
        io.SW_IN  = '0;
        repeat (3) @(negedge CLK);
        chk("reset_key_lvl", 32'(io.KEY_LVL), 0);
        chk("reset_sw_out", 32'(io.SW_OUT), 0);
        cmp_en = 1'b1;
        RST_N  = 1'b1;
        repeat (5) @(negedge CLK);

        // Key 0 pressed and held: press at edge 17, repeats at 81/97/113.
        io.KEY_IN[0] = 1'b0;
        prs_e = -1; prs_n = 0; other = 1'b0; reps.delete();
        for (int e = 0; e <= 120; e++) begin
            @(negedge CLK);
            if (io.KEY_PRESS[0]) begin prs_n++; if (prs_e < 0) prs_e = e; end
            if (io.KEY_REPEAT[0]) reps.push_back(e);
            if (e == 16) chk("a_lvl_e16", 32'(io.KEY_LVL[0]), 0);
            if (e == 17) chk("a_lvl_e17", 32'(io.KEY_LVL), 32'h1);
            if (io.KEY_LVL[3:1] != 0 || io.KEY_PRESS[3:1] != 0) other = 1'b1;
        end
        chk("a_press_edge", prs_e, 17);
        chk("a_press_count", prs_n, 1);
        chk("a_rep_count", reps.size(), 3);
        chk("a_rep0", reps.size() > 0 ? reps[0] : -1, 81);
        chk("a_rep1", reps.size() > 1 ? reps[1] : -1, 97);
        chk("a_rep2", reps.size() > 2 ? reps[2] : -1, 113);
        chk("a_other_keys", 32'(other), 0);
        io.KEY_IN[0] = 1'b1;
        repeat (30) @(negedge CLK);

        // Key 0 held through edge 89, released from edge 90: release at 107, last repeat 97.
        io.KEY_IN[0] = 1'b0;
        rel_e = -1; reps.delete();
        for (int e = 0; e <= 140; e++) begin
            @(negedge CLK);
            if (io.KEY_RELEASE[0] && rel_e < 0) rel_e = e;
            if (io.KEY_REPEAT[0]) reps.push_back(e);
            if (e == 108) chk("c_lvl_after_rel", 32'(io.KEY_LVL[0]), 0);
            if (e == 89) io.KEY_IN[0] = 1'b1;
        end
        chk("c_release_edge", rel_e, 107);
        chk("c_rep_count", reps.size(), 2);
        chk("c_rep_last", reps.size() > 0 ? reps[reps.size() - 1] : -1, 97);
        repeat (5) @(negedge CLK);

        // Key 1 glitches of 15 low samples never get through.
        act1 = 1'b0;
        for (int r = 0; r < 5; r++) begin
            io.KEY_IN[1] = 1'b0;
            tick_key1(15);
            io.KEY_IN[1] = 1'b1;
            tick_key1(5);
        end
        tick_key1(20);
        chk("b_key1_quiet", 32'(act1), 0);

        // Switch word change: accepted at edge 17 with a single change strobe.
        io.SW_IN = 10'h201;
        chg_e = -1; chg_n = 0;
        for (int e = 0; e <= 25; e++) begin
            @(negedge CLK);
            if (io.SW_CHANGED) begin chg_n++; if (chg_e < 0) chg_e = e; end
            if (e == 16) chk("d_sw_e16", 32'(io.SW_OUT), 0);
            if (e == 17) chk("d_sw_e17", 32'(io.SW_OUT), 32'h201);
        end
        chk("d_chg_count", chg_n, 1);
        chk("d_chg_edge", chg_e, 17);

        // Keys 2 and 3 pressed three cycles apart.
        io.KEY_IN[2] = 1'b0;
        p2 = -1; p3 = -1;
        for (int e = 0; e <= 30; e++) begin
            @(negedge CLK);
            if (io.KEY_PRESS[2] && p2 < 0) p2 = e;
            if (io.KEY_PRESS[3] && p3 < 0) p3 = e;
            if (e == 2) io.KEY_IN[3] = 1'b0;
        end
        chk("e_press2_edge", p2, 17);
        chk("e_press3_edge", p3, 20);
        io.KEY_IN[3:2] = 2'b11;
        repeat (30) @(negedge CLK);

        // Reset mid-hold: outputs clear at once, press re-detected 18 edges after release.
        io.KEY_IN[0] = 1'b0;
        for (int e = 0; e <= 40; e++) @(negedge CLK);
        chk("f_lvl_before_rst", 32'(io.KEY_LVL[0]), 1);
        RST_N = 1'b0;
        #1;
        chk("f_outputs_in_rst",
            32'({io.KEY_LVL, io.KEY_PRESS, io.KEY_RELEASE, io.KEY_REPEAT, io.SW_OUT, io.SW_CHANGED}), 0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        prs_e = -1;
        for (int e = 0; e <= 25; e++) begin
            @(negedge CLK);
            if (io.KEY_PRESS[0] && prs_e < 0) prs_e = e;
            if (e == 0) chk("f_no_pulse_first_edge", 32'({io.KEY_PRESS, io.KEY_RELEASE, io.SW_CHANGED}), 0);
        end
        chk("f_repress_edge", prs_e, 17);

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
